// File: rtl/demux_1_4_stream_pkg.sv
// Shared constants and types for the 1:4 stream demultiplexer.
// Optional per-port beat counters are enabled with DEMUX_1_4_STREAM_CNT_EN.
package demux_1_4_stream_pkg;

    localparam int N_OUT = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    // One-hot decode of a destination select.
    function automatic logic [N_OUT-1:0] sel_onehot(input sel_t sel);
        logic [N_OUT-1:0] oh;
        oh = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_1_4_stream_slot.sv
// demux_slot: one-entry output buffer for a single demux port.
// A load in the same cycle as a drain replaces the entry, so the port
// sustains one beat per cycle with no bubble.
// With DEMUX_1_4_STREAM_CNT_EN defined, it also counts drained beats
// (wrapping, cleared only by reset).
import demux_1_4_stream_pkg::*;

module demux_slot #(
    parameter int W = 4
`ifdef DEMUX_1_4_STREAM_CNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         drain,
    output logic         valid,
    output logic [W-1:0] data
`ifdef DEMUX_1_4_STREAM_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         fire;

    // A drain only happens when the slot actually holds a beat.
    assign fire = valid_q & drain;

    // Next entry state: a load always wins, otherwise a drain empties the slot.
    always_comb begin
        valid_d = load | (valid_q & ~fire);
        data_d  = load ? load_data : data_q;
    end

    // Entry registers; reset discards any in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

`ifdef DEMUX_1_4_STREAM_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Delivered-beat count, wraps naturally at 2^CNT_W.
    always_comb begin
        cnt_d = fire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
`endif

endmodule

// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream: routes each input beat to one of four buffered output
// ports selected by in_sel. Optional per-port delivered-beat counters are
// enabled with DEMUX_1_4_STREAM_CNT_EN.
//
// Handshake: a beat transfers on any interface in a cycle where valid and
// ready are both high at the rising clock edge. A producer holding valid
// must keep its payload stable until the transfer. in_ready depends only
// on in_sel, the target slot state and out_ready, never on in_valid.
import demux_1_4_stream_pkg::*;

module demux_1_4_stream #(
    parameter int W = 4
`ifdef DEMUX_1_4_STREAM_CNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    input  logic [1:0]         in_sel,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*W-1:0]     out_data
`ifdef DEMUX_1_4_STREAM_CNT_EN
    ,
    output logic [4*CNT_W-1:0] out_cnt
`endif
);

    sel_t             sel;
    logic [N_OUT-1:0] slot_valid;
    logic [N_OUT-1:0] load_vec;
    logic             accept;

    assign sel = in_sel;

    // The target port can take a beat if it is empty or draining this cycle.
    assign in_ready = ~slot_valid[sel] | out_ready[sel];
    assign accept   = in_valid & in_ready;
    assign load_vec = accept ? sel_onehot(sel) : '0;

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_slot #(
            .W         (W)
`ifdef DEMUX_1_4_STREAM_CNT_EN
            ,
            .CNT_W     (CNT_W)
`endif
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load_vec[k]),
            .load_data (in_data),
            .drain     (out_ready[k]),
            .valid     (slot_valid[k]),
            .data      (out_data[k*W +: W])
`ifdef DEMUX_1_4_STREAM_CNT_EN
            ,
            .cnt       (out_cnt[k*CNT_W +: CNT_W])
`endif
        );
    end

    assign out_valid = slot_valid;

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Testbench for demux_1_4_stream: directed scenarios plus randomized traffic,
// checked against per-port expected-beat queues.
module tb_demux_1_4_stream;

    localparam int W     = 4;
    localparam int CNT_W = 8;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [1:0]     in_sel;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;
    logic [4*W-1:0] out_data;
`ifdef DEMUX_1_4_STREAM_CNT_EN
    logic [4*CNT_W-1:0] out_cnt;
`endif

    always #5 clk = ~clk;

    demux_1_4_stream #(
        .W         (W)
`ifdef DEMUX_1_4_STREAM_CNT_EN
        ,
        .CNT_W     (CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DEMUX_1_4_STREAM_CNT_EN
        ,
        .out_cnt   (out_cnt)
`endif
    );

    // ---------------- scoreboard / reference model ----------------
    // Each port is a FIFO of beats accepted but not yet delivered; the
    // one-entry buffer means a port is "full" when its queue is non-empty.
    logic [W-1:0] exp_q[4][$];
    int           exp_cnt[4];
    int           total = 0;
    int           bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        return (exp_q[in_sel].size() == 0) || out_ready[in_sel];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            exp_cnt[k] = 0;
        end
    endtask

    // Compare every observable output against the model.
    task automatic check_outputs();
        chk("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("out_valid[%0d]", k), {31'd0, out_valid[k]},
                {31'd0, exp_q[k].size() != 0});
            if (exp_q[k].size() != 0)
                chk($sformatf("out_data[%0d]", k), 32'(out_data[k*W +: W]), 32'(exp_q[k][0]));
`ifdef DEMUX_1_4_STREAM_CNT_EN
            chk($sformatf("out_cnt[%0d]", k), 32'(out_cnt[k*CNT_W +: CNT_W]),
                32'(exp_cnt[k] % (1 << CNT_W)));
`endif
        end
    endtask

    // ---------------- driver ----------------
    // One clock: check at negedge, update model at posedge, return #1 later
    // so the caller can drive the next inputs away from the edge.
    task automatic step();
        logic rdy;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            rdy = model_ready();
            for (int k = 0; k < 4; k++) begin
                if (exp_q[k].size() != 0 && out_ready[k]) begin
                    void'(exp_q[k].pop_front());
                    exp_cnt[k]++;
                end
            end
            if (in_valid && rdy) exp_q[in_sel].push_back(in_data);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                         input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        rst_n = 1'b0;
        drive(1'b1, 2'd1, 4'h3, 4'hF);

        // Reset held with in_valid high: nothing loads, in_ready high.
        #1;
        chk("rst out_valid", {28'd0, out_valid}, 32'h0);
        chk("rst out_data", 32'(out_data), 32'h0);
        chk("rst in_ready", {31'd0, in_ready}, 32'h1);
        repeat (3) step();
        chk("rst hold out_valid", {28'd0, out_valid}, 32'h0);
        rst_n = 1'b1;

        // 0xA to port 2, then 0x5 to port 0.
        drive(1'b1, 2'd2, 4'hA, 4'hF);
        step();
        chk("p2 valid", {31'd0, out_valid[2]}, 32'h1);
        chk("p2 data", 32'(out_data[2*W +: W]), 32'hA);
        drive(1'b1, 2'd0, 4'h5, 4'hF);
        step();
        chk("p0 data", 32'(out_data[0 +: W]), 32'h5);
        chk("p2 drained", {31'd0, out_valid[2]}, 32'h0);
        drive(1'b0, 2'd0, 4'h0, 4'hF);
        step();

        // Port 1 stalled: fill it, then a second sel=1 beat must wait.
        drive(1'b1, 2'd1, 4'h7, 4'b1101);
        step();
        drive(1'b1, 2'd1, 4'h8, 4'b1101);
        #1;
        chk("stall in_ready", {31'd0, in_ready}, 32'h0);
        step();
        chk("stall p1 held", 32'(out_data[1*W +: W]), 32'h7);
        drive(1'b1, 2'd3, 4'h9, 4'b0101);
        #1;
        chk("bypass in_ready", {31'd0, in_ready}, 32'h1);
        step();
        chk("bypass p3 data", 32'(out_data[3*W +: W]), 32'h9);
        drive(1'b1, 2'd1, 4'h8, 4'hF);
        #1;
        chk("release in_ready", {31'd0, in_ready}, 32'h1);
        step();
        chk("release p1 data", 32'(out_data[1*W +: W]), 32'h8);
        drive(1'b0, 2'd0, 4'h0, 4'hF);
        step();

        // Back-to-back stream 1..F to port 3.
        for (int i = 1; i < 16; i++) begin
            drive(1'b1, 2'd3, W'(i), 4'hF);
            #1;
            chk("b2b in_ready", {31'd0, in_ready}, 32'h1);
            step();
            chk("b2b p3 data", 32'(out_data[3*W +: W]), 32'(i));
        end
        drive(1'b0, 2'd0, 4'h0, 4'hF);
        step();

        // Fill three slots, then pulse reset mid-cycle.
        drive(1'b1, 2'd0, 4'h1, 4'h0);
        step();
        drive(1'b1, 2'd1, 4'h2, 4'h0);
        step();
        drive(1'b1, 2'd2, 4'h3, 4'h0);
        step();
        drive(1'b0, 2'd0, 4'h0, 4'h0);
        chk("pre-rst full", {28'd0, out_valid}, 32'h7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", {28'd0, out_valid}, 32'h0);
        chk("async rst in_ready", {31'd0, in_ready}, 32'h1);
        model_reset();
        step();
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 4'h0, 4'hF);
        repeat (3) begin
            step();
            chk("no stale beat", {28'd0, out_valid}, 32'h0);
        end

`ifdef DEMUX_1_4_STREAM_CNT_EN
        // 260 drains on port 0 wrap an 8-bit counter to 4.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(1'b1, 2'd0, 4'h6, 4'hF);
        repeat (260) step();
        drive(1'b0, 2'd0, 4'h0, 4'hF);
        step();
        chk("cnt0 wrap", 32'(out_cnt[0 +: CNT_W]), 32'd4);
        chk("cnt1", 32'(out_cnt[1*CNT_W +: CNT_W]), 32'd0);
        chk("cnt2", 32'(out_cnt[2*CNT_W +: CNT_W]), 32'd0);
        chk("cnt3", 32'(out_cnt[3*CNT_W +: CNT_W]), 32'd0);
`endif

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  W'($urandom), 4'($urandom_range(0, 15)));
            step();
        end
        drive(1'b0, 2'd0, 4'h0, 4'hF);
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
